// File: rtl/adquisicion_de_temperatura.sv
// Reads an 8-bit temperature over a 3-wire link and holds its 4-bit code on temp.
// Latency: temp/temp_valida update 17*DIV+1 cycles after cs_n falls.
// Backpressure: none; conversions repeat every 17*DIV+PERIODO+2 cycles while enabled.
module adquisicion_de_temperatura #(
    parameter int DIV     = 25,
    parameter int PERIODO = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       habilitar,
    input  logic       sdata,
    output logic       cs_n,
    output logic       sclk,
    output logic [3:0] temp,
    output logic       temp_valida
);

    localparam int MAXC = (DIV > PERIODO) ? DIV : PERIODO;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        REPOSO,
        SELECCION,
        LECTURA,
        CODIFICA,
        ESPERA
    } estado_t;

    estado_t        estado_q, estado_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [4:0]     mitad_q, mitad_d;
    logic [7:0]     dato_q, dato_d;
    logic           cs_n_q, cs_n_d;
    logic           sclk_q, sclk_d;
    logic [3:0]     temp_q, temp_d;
    logic           valida_q, valida_d;

    // Saturating map from whole degrees to the decoder's 4-bit scale (37 C -> 8).
    function automatic logic [3:0] codificar(input logic [7:0] t);
        logic [3:0] c;
        if (t <= 8'd29) begin
            c = 4'd0;
        end else if (t >= 8'd44) begin
            c = 4'd15;
        end else begin
            c = 4'(t - 8'd29);
        end
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= REPOSO;
            cnt_q    <= '0;
            mitad_q  <= '0;
            dato_q   <= '0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            temp_q   <= 4'd8;
            valida_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            mitad_q  <= mitad_d;
            dato_q   <= dato_d;
            cs_n_q   <= cs_n_d;
            sclk_q   <= sclk_d;
            temp_q   <= temp_d;
            valida_q <= valida_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        mitad_d  = mitad_q;
        dato_d   = dato_q;
        cs_n_d   = cs_n_q;
        sclk_d   = sclk_q;
        temp_d   = temp_q;
        valida_d = 1'b0;

        unique case (estado_q)
            REPOSO: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                if (habilitar) begin
                    estado_d = SELECCION;
                    cs_n_d   = 1'b0;
                    cnt_d    = '0;
                    mitad_d  = '0;
                    dato_d   = '0;
                end
            end

            SELECCION: begin
                // Setup time ends with the first sclk rise, which also takes the MSB.
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_d    = '0;
                    estado_d = LECTURA;
                    sclk_d   = 1'b1;
                    mitad_d  = 5'd1;
                    dato_d   = {dato_q[6:0], sdata};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            LECTURA: begin
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_d = '0;
                    if (mitad_q == 5'd16) begin
                        // sclk already low; this extra half-period is the hold before release.
                        estado_d = CODIFICA;
                    end else begin
                        mitad_d = mitad_q + 5'd1;
                        sclk_d  = ~sclk_q;
                        if (!sclk_q) begin
                            dato_d = {dato_q[6:0], sdata};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            CODIFICA: begin
                cs_n_d   = 1'b1;
                sclk_d   = 1'b0;
                temp_d   = codificar(dato_q);
                valida_d = 1'b1;
                cnt_d    = '0;
                mitad_d  = '0;
                estado_d = ESPERA;
            end

            ESPERA: begin
                cs_n_d = 1'b1;
                if (cnt_q == CW'(PERIODO - 1)) begin
                    cnt_d    = '0;
                    estado_d = REPOSO;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                estado_d = REPOSO;
                cs_n_d   = 1'b1;
                sclk_d   = 1'b0;
                cnt_d    = '0;
                mitad_d  = '0;
            end
        endcase
    end

    assign cs_n        = cs_n_q;
    assign sclk        = sclk_q;
    assign temp        = temp_q;
    assign temp_valida = valida_q;

endmodule
